// File: rtl/fir_result_fifo_if.sv
// Handshake bundle between the FIR accelerator, the result FIFO and its consumer.
// The master side drives the producer and consumer inputs; the slave side is the FIFO.
interface fir_result_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 16
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic signed [DATA_WIDTH-1:0] macResult;
    logic                         resultIsValid;
    logic signed [DATA_WIDTH-1:0] outData;
    logic                         outValid;
    logic                         outReady;
    logic [PTR_WIDTH:0]           count;
    logic                         full;
    logic                         empty;
    logic                         overflow;
    logic                         clearOverflow;
    logic [DROP_WIDTH-1:0]        dropCount;

    modport master (
        output macResult, resultIsValid, outReady, clearOverflow,
        input  outData, outValid, count, full, empty, overflow, dropCount
    );

    modport slave (
        input  macResult, resultIsValid, outReady, clearOverflow,
        output outData, outValid, count, full, empty, overflow, dropCount
    );
endinterface

// File: rtl/fir_result_fifo.sv
// Show-ahead circular result buffer behind the FIR accelerator; drops on full
// (the FIR cannot be stalled) and keeps a sticky overflow flag plus a saturating drop count.
module fir_result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rstN,
    fir_result_fifo_if.slave  bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,    count_d;
    logic                  full_q,     full_d;
    logic                  empty_q,    empty_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic push_s;
    logic pop_s;
    logic drop_s;

    // Next-state computation for pointers, occupancy, head register and overflow tracking.
    always_comb begin
        pop_s  = out_valid_q && bus.outReady;
        push_s = bus.resultIsValid && (!full_q || pop_s);
        drop_s = bus.resultIsValid && full_q && !pop_s;

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_WIDTH'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_WIDTH'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        full_d      = (count_d == CNT_WIDTH'(DEPTH));
        empty_d     = (count_d == CNT_WIDTH'(0));
        out_valid_d = !empty_d;

        // The slot being written this edge is not yet in mem_q, so forward it when it becomes the head.
        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = bus.macResult;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end

        if (drop_s) begin
            overflow_d = 1'b1;
            if (bus.clearOverflow) begin
                drop_cnt_d = DROP_WIDTH'(1);
            end else if (drop_cnt_q == {DROP_WIDTH{1'b1}}) begin
                drop_cnt_d = drop_cnt_q;
            end else begin
                drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
            end
        end else if (bus.clearOverflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = DROP_WIDTH'(0);
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Sample storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.macResult;
        end
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q    <= PTR_WIDTH'(0);
            rd_ptr_q    <= PTR_WIDTH'(0);
            count_q     <= CNT_WIDTH'(0);
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= DATA_WIDTH'(0);
            overflow_q  <= 1'b0;
            drop_cnt_q  <= DROP_WIDTH'(0);
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.outData   = out_data_q;
    assign bus.outValid  = out_valid_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.dropCount = drop_cnt_q;
endmodule

// File: tb/tb_fir_result_fifo.sv
// Self-checking bench for fir_result_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fir_result_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int DROPW = 16;

    localparam logic [DW-1:0] Q_ONE   = 16'h0100;
    localparam logic [DW-1:0] Q_TWO   = 16'h0200;
    localparam logic [DW-1:0] Q_THREE = 16'h0300;
    localparam logic [DW-1:0] Q_M2P5  = 16'hFD80;

    logic clk;
    logic rstN;

    fir_result_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_WIDTH(DROPW)) bus ();

    fir_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_WIDTH(DROPW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            m_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // Advance the reference model by one clock using the current inputs, then move to the next falling edge.
    task automatic tick();
        bit pop;
        bit full;
        bit push;
        bit drop;
        pop  = (mq.size() > 0) && bus.outReady;
        full = (mq.size() == DEPTH);
        push = bus.resultIsValid && (!full || pop);
        drop = bus.resultIsValid && full && !pop;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(bus.macResult);
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = bus.clearOverflow ? 1 : ((m_drop == (1 << DROPW) - 1) ? m_drop : m_drop + 1);
        end else if (bus.clearOverflow) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.macResult = '0; bus.resultIsValid = 1'b0;
        bus.outReady = 1'b0; bus.clearOverflow = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.outValid !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0 ||
            bus.overflow !== 1'b0 || bus.dropCount !== 16'd0 || bus.outData !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b empty=%b full=%b count=%0d ovf=%b drop=%0d data=%h expected 0 1 0 0 0 0 0000",
                     bus.outValid, bus.empty, bus.full, bus.count, bus.overflow, bus.dropCount, bus.outData);
        end
        rstN = 1'b1;
        bus.outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.outValid !== 1'b0 || bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset cycle %0d: valid=%b empty=%b count=%0d ovf=%b expected 0 1 0 0",
                         i, bus.outValid, bus.empty, bus.count, bus.overflow);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [3];
        vals[0] = Q_ONE; vals[1] = Q_TWO; vals[2] = Q_THREE;
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.macResult = vals[i]; bus.resultIsValid = 1'b1;
            tick();
            n_checks++;
            if (bus.outValid !== 1'b1 || bus.outData !== Q_ONE || bus.count !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_step %0d: valid=%b data=%h count=%0d expected 1 %h %0d",
                         i, bus.outValid, bus.outData, bus.count, Q_ONE, i + 1);
            end
        end
        bus.resultIsValid = 1'b0;
        bus.outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.outValid !== 1'b1 || bus.outData !== vals[i]) begin
                n_fail++;
                $display("FAIL drain_order %0d: valid=%b data=%h expected 1 %h", i, bus.outValid, bus.outData, vals[i]);
            end
            tick();
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.outValid !== 1'b0 || bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b valid=%b count=%0d expected 1 0 0", bus.empty, bus.outValid, bus.count);
        end
    endtask

    task automatic test_overflow();
        bus.outReady = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            bus.macResult = DW'(v); bus.resultIsValid = 1'b1;
            tick();
        end
        bus.resultIsValid = 1'b0;
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b1 || bus.dropCount !== 16'd2 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_flags: full=%b count=%0d ovf=%b drop=%0d empty=%b expected 1 8 1 2 0",
                     bus.full, bus.count, bus.overflow, bus.dropCount, bus.empty);
        end
        bus.outReady = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            n_checks++;
            if (bus.outValid !== 1'b1 || bus.outData !== DW'(v)) begin
                n_fail++;
                $display("FAIL overflow_drain %0d: valid=%b data=%0d expected 1 %0d", v, bus.outValid, bus.outData, v);
            end
            tick();
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: empty=%b ovf=%b expected 1 1", bus.empty, bus.overflow);
        end
        bus.clearOverflow = 1'b1;
        tick();
        bus.clearOverflow = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.dropCount !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_overflow: ovf=%b drop=%0d expected 0 0", bus.overflow, bus.dropCount);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_order [8];
        bus.outReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.macResult = DW'(100 + i); bus.resultIsValid = 1'b1;
            tick();
        end
        bus.outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.macResult = DW'(20 + i);
            tick();
            n_checks++;
            if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.dropCount !== 16'd0) begin
                n_fail++;
                $display("FAIL full_push_pop %0d: count=%0d full=%b ovf=%b drop=%0d expected 8 1 0 0",
                         i, bus.count, bus.full, bus.overflow, bus.dropCount);
            end
        end
        bus.resultIsValid = 1'b0;
        for (int i = 0; i < 4; i++) exp_order[i] = DW'(104 + i);
        for (int i = 0; i < 4; i++) exp_order[4 + i] = DW'(20 + i);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.outValid !== 1'b1 || bus.outData !== exp_order[i]) begin
                n_fail++;
                $display("FAIL full_pp_order %0d: valid=%b data=%0d expected 1 %0d", i, bus.outValid, bus.outData, exp_order[i]);
            end
            tick();
        end
    endtask

    task automatic test_clear_vs_drop();
        bus.outReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.macResult = DW'($urandom); bus.resultIsValid = 1'b1;
            tick();
        end
        bus.clearOverflow = 1'b1;
        tick();
        bus.resultIsValid = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.dropCount !== 16'd1) begin
            n_fail++;
            $display("FAIL clear_vs_drop: ovf=%b drop=%0d expected 1 1", bus.overflow, bus.dropCount);
        end
        tick();
        bus.clearOverflow = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.dropCount !== 16'd0 || bus.count !== 4'd8) begin
            n_fail++;
            $display("FAIL clear_only: ovf=%b drop=%0d count=%0d expected 0 0 8", bus.overflow, bus.dropCount, bus.count);
        end
        bus.outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.outData !== mq[0]) begin
                n_fail++;
                $display("FAIL clear_drain %0d: data=%h expected %h", i, bus.outData, mq[0]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] v;
        bus.outReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = DW'(1000 + i / 2);
            bus.macResult = v;
            bus.resultIsValid = (i % 2 == 0);
            tick();
            n_checks++;
            if (i % 2 == 0) begin
                if (bus.count !== 4'd1 || bus.outValid !== 1'b1 || bus.outData !== v) begin
                    n_fail++;
                    $display("FAIL wrap_push %0d: count=%0d valid=%b data=%0d expected 1 1 %0d",
                             i, bus.count, bus.outValid, bus.outData, v);
                end
            end else begin
                if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_pop %0d: count=%0d empty=%b expected 0 1", i, bus.count, bus.empty);
                end
            end
        end
        bus.resultIsValid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.macResult     = DW'($urandom);
            bus.resultIsValid = ($urandom_range(0, 99) < 60);
            bus.outReady      = ($urandom_range(0, 99) < 40);
            bus.clearOverflow = ($urandom_range(0, 99) < 4);
            tick();
            n_checks++;
            if (bus.outValid !== (mq.size() > 0) || bus.count !== 4'(mq.size()) ||
                bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0) ||
                bus.overflow !== m_ovf || bus.dropCount !== DROPW'(m_drop) ||
                (mq.size() > 0 && bus.outData !== mq[0])) begin
                n_fail++;
                $display("FAIL random %0d: valid=%b count=%0d full=%b empty=%b ovf=%b drop=%0d data=%h expected count=%0d ovf=%b drop=%0d data=%h",
                         i, bus.outValid, bus.count, bus.full, bus.empty, bus.overflow, bus.dropCount, bus.outData,
                         mq.size(), m_ovf, m_drop, (mq.size() > 0) ? mq[0] : 16'h0);
            end
        end
        bus.resultIsValid = 1'b0;
        bus.clearOverflow = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.outReady = 1'b0;
        bus.clearOverflow = 1'b0;
        while (mq.size() > 0) begin
            bus.outReady = 1'b1;
            tick();
        end
        bus.outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.macResult = DW'($urandom); bus.resultIsValid = 1'b1;
            tick();
        end
        bus.resultIsValid = 1'b0;
        n_checks++;
        if (bus.count !== 4'd5 || bus.outValid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async_count: count=%0d valid=%b expected 5 1", bus.count, bus.outValid);
        end
        #2 rstN = 1'b0;
        #1;
        n_checks++;
        if (bus.outValid !== 1'b0 || bus.count !== 4'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d full=%b ovf=%b empty=%b expected 0 0 0 0 1",
                     bus.outValid, bus.count, bus.full, bus.overflow, bus.empty);
        end
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
        bus.macResult = Q_M2P5; bus.resultIsValid = 1'b1;
        tick();
        bus.resultIsValid = 1'b0;
        n_checks++;
        if (bus.outValid !== 1'b1 || bus.outData !== Q_M2P5 || bus.count !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: valid=%b data=%h count=%0d expected 1 %h 1", bus.outValid, bus.outData, bus.count, Q_M2P5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_clear_vs_drop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_result_fifo.md
Name: fir_result_fifo

Overview:
- Output buffer directly downstream of the FIR accelerator top.
- Captures every `macResult` sample qualified by `resultIsValid` and holds it in a circular buffer.
- Presents samples to the consumer (bus/UART bridge) over a ready/valid handshake.
- The FIR has no backpressure, so the FIFO drops samples when full, raises a sticky overflow flag and counts the drops.

Parameters:
- DATA_WIDTH, 16: width of the signed Q-format result word; must match the FIR's DATA_WIDTH.
- DEPTH, 8: number of entries; power of two, minimum 2.
- PTR_WIDTH, $clog2(DEPTH): derived local parameter; do not override.
- DROP_WIDTH, 16: width of the dropped-sample counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rstN  input  1  asynchronous active-low reset.
- macResult  input  DATA_WIDTH  signed FIR result from the accelerator.
- resultIsValid  input  1  push qualifier; one sample per cycle while high.
- outData  output  DATA_WIDTH  head-of-FIFO sample (show-ahead).
- outValid  output  1  outData holds a valid sample.
- outReady  input  1  consumer accepts outData this cycle.
- count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a push is dropped.
- clearOverflow  input  1  synchronous clear of overflow and dropCount.
- dropCount  output  DROP_WIDTH  number of dropped samples, saturating.

Behaviour:
- Reset (rstN low, asynchronous):
  - Read and write pointers go to 0, count=0, empty=1, full=0, outValid=0.
  - outData=0, overflow=0, dropCount=0.
  - Storage contents are don't-care.
  - Deassertion is synchronised externally. First capture is on the first rising edge with rstN high.
- Pop:
  - pop = outValid && outReady.
  - Raising outReady while outValid=0 has no effect.
- Push acceptance:
  - push = resultIsValid && (!full || pop).
  - A push while full in the same cycle as a pop is accepted; count stays at DEPTH.
- Drop:
  - drop = resultIsValid && full && !pop.
  - The sample is discarded and storage is unchanged.
  - overflow <= 1 and dropCount increments, holding at all-ones.
- Count update each cycle:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
  - neither: unchanged.
- Pointers:
  - PTR_WIDTH bits; wrap naturally from DEPTH-1 to 0.
  - The write pointer advances on push, the read pointer on pop.
- Show-ahead output:
  - outData always reflects mem[readPtr], registered.
  - outValid = !empty, registered.
  - Latency: a sample pushed on edge N appears on outData/outValid after edge N when the FIFO was empty. Fall-through latency is one cycle.
- Push and pop on an empty FIFO in the same cycle are impossible, because outValid=0 means no pop.
- Ordering is strictly FIFO. No reordering, no data modification, signed value passed bit-exact.
- clearOverflow:
  - Clears overflow and dropCount on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, dropCount=1.
- FIR gating: when the FIR enable is low, resultIsValid stays low. The FIFO holds its state and continues to drain.
- Reset mid-operation: all contents are lost immediately and outValid falls asynchronously.
- full and empty are registered, consistent with count, and never both high.

Test Plan:
- Reset then idle: rstN low for 2 cycles → outValid=0, empty=1, count=0, overflow=0, dropCount=0. Stay idle 5 cycles with outReady=1 → no change.
- Fill and drain: push 1.0, 2.0, 3.0 (Q-format encoded) with outReady=0 → count=3, outData=1.0. Then outReady=1 for 3 cycles → outData sequence 1.0, 2.0, 3.0, then empty=1.
- Overflow: outReady=0, push 10 samples (values 1..10) into DEPTH=8 → full=1, count=8, overflow=1, dropCount=2. Drain yields 1..8 only. Then clearOverflow pulse → overflow=0, dropCount=0.
- Full with simultaneous push/pop: from full, resultIsValid=1 and outReady=1 for 4 cycles with values 20..23 → no drops, count stays 8. The drained order continues correctly, with 20..23 appearing after the original 8 entries.
- Pointer wrap: 20 push/pop pairs with pushes staggered one cycle ahead → count toggles between 0 and 1, every value is received in order, and pointers wrap twice without corruption.
- Async reset mid-stream: with count=5, assert rstN between clock edges → outValid, count, full and overflow drop immediately with no clock. After release, a new push of -2.5 appears as outData=-2.5 one cycle later.
